emif_weight_loader: RTL and testbench
=====================================

Name: emif_weight_loader

Overview:
- Controller that copies a contiguous block of 128-bit words from the EMIF memory model into a bank of weight buffers.
- Each weight buffer is a 4-deep, 128-bit single-port RAM.
- Started by a one-cycle start pulse from the top-level state machine; reports completion with a level done that the testbench waits on.
- Sits between the emif_inner instance and the weight-buffer instances and sequences both sides at one word per cycle.

Parameters:
- EMIF_ADDR_WIDTH, 14, EMIF word-address width.
- DATA_WIDTH, 128, word width on both EMIF and buffer sides.
- BUF_ADDR_WIDTH, 2, weight-buffer address width; depth D = 1<<BUF_ADDR_WIDTH.
- NUM_BUFS, 4, number of weight buffers driven.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load.
- base_addr  in  EMIF_ADDR_WIDTH  first EMIF word address; sampled with start.
- buf_count  in  $clog2(NUM_BUFS+1)  number of buffers to fill; sampled with start.
- busy  out  1  load in progress.
- done  out  1  last load complete; level signal.
- emif_address  out  EMIF_ADDR_WIDTH  EMIF read address.
- emif_wen  out  1  EMIF write enable; constant 0.
- emif_dataout  in  DATA_WIDTH  EMIF combinational read data.
- buf_addr  out  BUF_ADDR_WIDTH  shared buffer address.
- buf_datain  out  DATA_WIDTH  shared buffer write data.
- buf_we  out  NUM_BUFS  one-hot buffer write enables.

Behaviour:
- Reset values: busy=0, done=0, emif_address=0, emif_wen=0, buf_addr=0, buf_datain=0, buf_we=0. FSM goes to IDLE.
- Reset mid-load: abort at the next edge; no further buf_we pulses. Partially written buffer contents are left as-is.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE / DONE on start:
  - Latch base_addr.
  - Compute effective count C = min(buf_count, NUM_BUFS) and total words T = C*D.
  - Clear done and the word index idx.
  - If C==0: go to DONE (done rises the next cycle, no buf_we activity). Otherwise go to READ.
- start while in READ or DRAIN is ignored.
- READ:
  - emif_address = (base + idx) mod 2^EMIF_ADDR_WIDTH; wrap-around is silent.
  - Each edge registers emif_dataout together with its target: buffer idx/D, address idx mod D.
  - idx increments each cycle; after the edge where idx==T-1 is read, go to DRAIN.
- Write stage: in the cycle after each read, buf_we has exactly one bit set and buf_addr/buf_datain carry the registered word. Buffers commit on the following edge.
- DRAIN: emits the final write, then goes to DONE.
- DONE: done=1 and held until the next accepted start or reset.
- busy is 1 in READ and DRAIN only. emif_address is 0 outside READ.
- Timing, start sampled at edge 0:
  - EMIF reads occur in cycles 1..T.
  - buf_we pulses occur in cycles 2..T+1.
  - busy is high in cycles 1..T+1.
  - done is high from cycle T+2.
- Throughput is one word per cycle with no bubbles. Fill order is buffer 0 address 0..D-1, then buffer 1, and so on. Buffers at index ≥C are never written.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined: adds output port checksum [DATA_WIDTH].
  - Reset to 0 and cleared on each accepted start.
  - XOR-accumulates every word as it is written to a buffer.
  - Final value is valid when done rises and is held while in DONE.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset, then start with base_addr=0, buf_count=4, EMIF word k = k+1 → 16 buf_we pulses in cycles 2..17, buffer b address a = 4b+a+1; done high at cycle 18 and holds; busy low from cycle 18.
- base_addr=0x3FFE, buf_count=1 → emif_address sequence 0x3FFE, 0x3FFF, 0x0000, 0x0001; buffer 0 holds words from those addresses; buf_we[3:1] never asserted.
- buf_count=0 → done=1 one cycle after start; buf_we stays 0; busy never asserted.
- buf_count=7 (>NUM_BUFS) → clamped to 4; exactly 16 writes.
- Start pulsed again at cycle 5 of a 16-word load → ignored, sequence unchanged; start again in DONE → done drops next cycle, new load runs.
- Reset asserted at cycle 6 of a load → next cycle all outputs 0 and state IDLE; no buf_we afterward; a fresh start completes normally. With LOADER_CHECKSUM_EN, the first scenario gives checksum = XOR of 1..16 = 0x10.

Source files
------------

// File: rtl/emif_weight_loader.sv
// emif_weight_loader: copies C*D consecutive EMIF words into C weight buffers,
// one word per cycle, buffer 0 address 0..D-1 first, then buffer 1, and so on.
// Optional build macro LOADER_CHECKSUM_EN adds a running XOR of written words.
module emif_weight_loader #(
  parameter int unsigned EMIF_ADDR_WIDTH = 14,
  parameter int unsigned DATA_WIDTH      = 128,
  parameter int unsigned BUF_ADDR_WIDTH  = 2,
  parameter int unsigned NUM_BUFS        = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [EMIF_ADDR_WIDTH-1:0]        base_addr,
  input  logic [$clog2(NUM_BUFS+1)-1:0]     buf_count,
  output logic                              busy,
  output logic                              done,
  output logic [EMIF_ADDR_WIDTH-1:0]        emif_address,
  output logic                              emif_wen,
  input  logic [DATA_WIDTH-1:0]             emif_dataout,
  output logic [BUF_ADDR_WIDTH-1:0]         buf_addr,
  output logic [DATA_WIDTH-1:0]             buf_datain,
  output logic [NUM_BUFS-1:0]               buf_we
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0]             checksum
`endif
);

  localparam int unsigned DEPTH = 1 << BUF_ADDR_WIDTH;
  localparam int unsigned CNT_W = $clog2(NUM_BUFS + 1);
  localparam int unsigned SEL_W = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1;
  localparam int unsigned IDX_W = SEL_W + BUF_ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                       state_q;
  logic [IDX_W-1:0]             idx_q;
  logic [IDX_W-1:0]             last_idx_q;
  logic [EMIF_ADDR_WIDTH-1:0]   emif_address_q;
  logic                         busy_q;
  logic                         done_q;
  logic [BUF_ADDR_WIDTH-1:0]    buf_addr_q;
  logic [DATA_WIDTH-1:0]        buf_datain_q;
  logic [NUM_BUFS-1:0]          buf_we_q;

  logic [CNT_W-1:0]             count_d;
  logic [IDX_W-1:0]             last_idx_d;
  logic [SEL_W-1:0]             sel_d;
  logic [NUM_BUFS-1:0]          we_d;
  logic                         start_acc_d;

  // Clamp the requested count, derive the final word index and the write target.
  always_comb begin
    count_d     = (buf_count > CNT_W'(NUM_BUFS)) ? CNT_W'(NUM_BUFS) : buf_count;
    last_idx_d  = IDX_W'((32'(count_d) * DEPTH) - 32'd1);
    sel_d       = idx_q[IDX_W-1:BUF_ADDR_WIDTH];
    we_d        = NUM_BUFS'(1) << sel_d;
    start_acc_d = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  end

  // Load sequencer: read stage in READ, write stage one cycle behind it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      last_idx_q     <= '0;
      emif_address_q <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      buf_addr_q     <= '0;
      buf_datain_q   <= '0;
      buf_we_q       <= '0;
    end else begin
      buf_we_q <= '0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            emif_address_q <= base_addr;
            idx_q          <= '0;
            last_idx_q     <= last_idx_d;
            if (count_d == '0) begin
              emif_address_q <= '0;
              done_q         <= 1'b1;
              state_q        <= S_DONE;
            end else begin
              done_q  <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= S_READ;
            end
          end
        end
        S_READ: begin
          buf_datain_q <= emif_dataout;
          buf_addr_q   <= idx_q[BUF_ADDR_WIDTH-1:0];
          buf_we_q     <= we_d;
          idx_q        <= idx_q + IDX_W'(1);
          if (idx_q == last_idx_q) begin
            emif_address_q <= '0;
            state_q        <= S_DRAIN;
          end else begin
            emif_address_q <= emif_address_q + EMIF_ADDR_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_q;

  // XOR every word on the edge it commits into a buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum_q <= '0;
    end else if (start_acc_d) begin
      checksum_q <= '0;
    end else if (|buf_we_q) begin
      checksum_q <= checksum_q ^ buf_datain_q;
    end
  end

  assign checksum = checksum_q;
`endif

  assign busy         = busy_q;
  assign done         = done_q;
  assign emif_address = emif_address_q;
  assign emif_wen     = 1'b0;
  assign buf_addr     = buf_addr_q;
  assign buf_datain   = buf_datain_q;
  assign buf_we       = buf_we_q;

endmodule

// File: tb/tb_emif_weight_loader.sv
// Directed bench for emif_weight_loader; EMIF word at address a is a+1+(salt<<64).
module tb_emif_weight_loader;

  localparam logic [127:0] SENT = 128'hDEAD_BEEF;

  logic         clk;
  logic         reset;
  logic         start;
  logic [13:0]  base_addr;
  logic [2:0]   buf_count;
  logic         busy;
  logic         done;
  logic [13:0]  emif_address;
  logic         emif_wen;
  logic [127:0] emif_dataout;
  logic [1:0]   buf_addr;
  logic [127:0] buf_datain;
  logic [3:0]   buf_we;
`ifdef LOADER_CHECKSUM_EN
  logic [127:0] checksum;
`endif

  logic [31:0]  salt;
  logic [127:0] bufm [4][4];
  int           n_checks;
  int           n_pass;

  emif_weight_loader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .base_addr    (base_addr),
    .buf_count    (buf_count),
    .busy         (busy),
    .done         (done),
    .emif_address (emif_address),
    .emif_wen     (emif_wen),
    .emif_dataout (emif_dataout),
    .buf_addr     (buf_addr),
    .buf_datain   (buf_datain),
    .buf_we       (buf_we)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum     (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational EMIF memory model.
  always_comb emif_dataout = 128'(emif_address) + 128'd1 + (128'(salt) << 64);

  function automatic logic [127:0] mem_word(input logic [13:0] a);
    return 128'(a) + 128'd1 + (128'(salt) << 64);
  endfunction

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Runs one load, checking every cycle; optional ignored start or mid-load reset.
  task automatic run_load(input logic [13:0] base, input logic [2:0] cnt, input int exp_c,
                          input int glitch_cyc, input int rst_cyc);
    int           t;
    int           writes;
    logic [127:0] xacc;
    logic [127:0] exp_data;
    logic [13:0]  exp_addr;
    logic [3:0]   exp_we;
    logic         exp_busy;
    logic         exp_done;
    t      = exp_c * 4;
    writes = 0;
    xacc   = '0;
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 4; a++) bufm[b][a] = SENT;
    base_addr = base;
    buf_count = cnt;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= t + 3; cyc++) begin
      exp_busy = (t > 0) && (cyc <= t + 1);
      exp_done = (t == 0) ? 1'b1 : (cyc >= t + 2);
      exp_addr = ((t > 0) && (cyc <= t)) ? 14'(base + 14'(cyc - 1)) : 14'd0;
      exp_we   = ((t > 0) && (cyc >= 2) && (cyc <= t + 1)) ? (4'd1 << ((cyc - 2) / 4)) : 4'd0;
      check_val($sformatf("busy c%0d", cyc), 128'(busy), 128'(exp_busy));
      check_val($sformatf("done c%0d", cyc), 128'(done), 128'(exp_done));
      check_val($sformatf("emif_address c%0d", cyc), 128'(emif_address), 128'(exp_addr));
      check_val($sformatf("buf_we c%0d", cyc), 128'(buf_we), 128'(exp_we));
      check_val($sformatf("emif_wen c%0d", cyc), 128'(emif_wen), 128'd0);
      if (exp_we != 4'd0) begin
        exp_data = mem_word(14'(base + 14'(cyc - 2)));
        xacc     = xacc ^ exp_data;
        check_val($sformatf("buf_addr c%0d", cyc), 128'(buf_addr), 128'((cyc - 2) % 4));
        check_val($sformatf("buf_datain c%0d", cyc), buf_datain, exp_data);
      end
      if (buf_we != 4'd0) begin
        writes++;
        for (int b = 0; b < 4; b++) if (buf_we[b]) bufm[b][buf_addr] = buf_datain;
      end
      if (cyc == rst_cyc) begin
        reset = 1'b1;
        @(negedge clk);
        check_val("rst busy", 128'(busy), 128'd0);
        check_val("rst done", 128'(done), 128'd0);
        check_val("rst emif_address", 128'(emif_address), 128'd0);
        check_val("rst buf_addr", 128'(buf_addr), 128'd0);
        check_val("rst buf_datain", buf_datain, 128'd0);
        check_val("rst buf_we", 128'(buf_we), 128'd0);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check_val($sformatf("post-rst buf_we %0d", k), 128'(buf_we), 128'd0);
          check_val($sformatf("post-rst busy %0d", k), 128'(busy), 128'd0);
        end
        return;
      end
      start = (cyc == glitch_cyc);
      if (cyc == glitch_cyc) begin
        base_addr = ~base;
        buf_count = 3'd1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check_val("write count", 128'(writes), 128'(t));
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 4; a++)
        check_val($sformatf("buf%0d[%0d]", b, a), bufm[b][a],
                  (b < exp_c) ? mem_word(14'(base + 14'(4 * b + a))) : SENT);
`ifdef LOADER_CHECKSUM_EN
    check_val("checksum", checksum, xacc);
`endif
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    salt      = 32'd0;
    reset     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    buf_count = '0;
    @(negedge clk);
    @(negedge clk);
    check_val("reset busy", 128'(busy), 128'd0);
    check_val("reset done", 128'(done), 128'd0);
    check_val("reset emif_address", 128'(emif_address), 128'd0);
    check_val("reset emif_wen", 128'(emif_wen), 128'd0);
    check_val("reset buf_addr", 128'(buf_addr), 128'd0);
    check_val("reset buf_datain", buf_datain, 128'd0);
    check_val("reset buf_we", 128'(buf_we), 128'd0);
    reset = 1'b0;
    @(negedge clk);

    // Full load, words 1..16.
    run_load(14'h0000, 3'd4, 4, 0, 0);
`ifdef LOADER_CHECKSUM_EN
    check_val("checksum literal", checksum, 128'h10);
`endif
    // Address wrap with a single buffer.
    salt = 32'h0000_00A5;
    run_load(14'h3FFE, 3'd1, 1, 0, 0);
    // Zero-count request.
    run_load(14'h0100, 3'd0, 0, 0, 0);
    // Over-range count is clamped.
    salt = 32'h1234_5678;
    run_load(14'h0200, 3'd7, 4, 0, 0);
    // Start during READ ignored; start from DONE re-arms.
    run_load(14'h0010, 3'd4, 4, 5, 0);
    // Reset mid-load, then a fresh load.
    run_load(14'h0020, 3'd4, 4, 0, 6);
    salt = 32'hCAFE_0001;
    run_load(14'h0040, 3'd2, 2, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
